fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage RV32I pipeline. It replaces the bare PC register, PC+4 adder, PC mux and IF/ID registers.
- Issues sequential ROM addresses and supports both combinational (latency 0) and registered (latency 1) instruction ROMs.
- Buffers fetched instructions in a DEPTH-entry FIFO, so decode stalls do not stop fetch.
- A taken branch/jump redirect from EX flushes the queue and any in-flight ROM response.

---
 rtl/fetch_queue_unit.sv | 103 ++++++++++
 tb/tb_fetch_queue_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC issue to a latency-0/1 ROM,
// DEPTH-entry fetch queue feeding decode, flushed by EX redirects.
module fetch_queue_unit #(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     DEPTH       = 4,
  parameter int unsigned     ROM_LATENCY = 1,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h00000013)
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [WIDTH-1:0]         rom_address,
  output logic                     rom_req,
  input  logic [WIDTH-1:0]         rom_data,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_target,
  input  logic                     stall_d,
  output logic [WIDTH-1:0]         instr_d,
  output logic [WIDTH-1:0]         pc_d,
  output logic [WIDTH-1:0]         pc_plus4_d,
  output logic                     valid_d,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam bit          LAT0  = (ROM_LATENCY == 0);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] pend_pc;
  logic             pending;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic             issue;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] enq_pc;

  // Issue/enqueue/dequeue decisions; redirect suppresses all of them.
  always_comb begin
    occupancy = count + CNT_W'(pending);
    issue     = !reset && !redirect && (occupancy < CNT_W'(DEPTH));
    enq       = LAT0 ? issue : (pending && !redirect);
    enq_pc    = LAT0 ? fetch_pc : pend_pc;
    deq       = valid_d && !stall_d && !redirect;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + WIDTH'(4);
      if (enq)   wr_ptr   <= wr_ptr + PTR_W'(1);
      if (deq)   rd_ptr   <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A latency-1 request stays in flight for exactly one cycle.
      if (!LAT0) begin
        pending <= issue;
        if (issue) pend_pc <= fetch_pc;
      end
    end
  end

  // Queue storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (enq) begin
      instr_mem[wr_ptr] <= rom_data;
      pc_mem[wr_ptr]    <= enq_pc;
    end
  end

  always_comb begin
    valid_d     = (count != '0);
    instr_d     = valid_d ? instr_mem[rd_ptr] : NOP_INSTR;
    pc_d        = valid_d ? pc_mem[rd_ptr] : '0;
    pc_plus4_d  = pc_d + WIDTH'(4);
    rom_address = fetch_pc;
    rom_req     = issue;
    queue_count = occupancy;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: three instances (latency 1, latency 0, wrapping
// reset PC) share stimulus and are checked against a queue-based reference.
module tb_fetch_queue_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC_C = 32'hFFFF_FFF8;
  localparam int unsigned NQ    = 4;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic        stall_d;
  logic [31:0] redirect_target;

  logic [31:0] rom_address [3];
  logic [31:0] rom_data    [3];
  logic [31:0] instr_d     [3];
  logic [31:0] pc_d        [3];
  logic [31:0] pc_plus4_d  [3];
  logic        rom_req     [3];
  logic        valid_d     [3];
  logic [2:0]  queue_count [3];
  logic [31:0] rom_q0;
  logic [31:0] rom_q2;

  int n_vec;
  int n_err;

  // Reference state: queued PCs, in-flight PCs and the fetch PC per instance.
  logic [31:0] mq [3][$];
  logic [31:0] mp [3][$];
  logic [31:0] mf [3];

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        v;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        req;
    logic [2:0]  qc;
  } vec_t;

  vec_t tbl [20];

  fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .ROM_LATENCY(1), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut_a (
    .clock(clock), .reset(reset), .rom_address(rom_address[0]), .rom_req(rom_req[0]),
    .rom_data(rom_data[0]), .redirect(redirect), .redirect_target(redirect_target),
    .stall_d(stall_d), .instr_d(instr_d[0]), .pc_d(pc_d[0]), .pc_plus4_d(pc_plus4_d[0]),
    .valid_d(valid_d[0]), .queue_count(queue_count[0]));

  fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .ROM_LATENCY(0), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut_b (
    .clock(clock), .reset(reset), .rom_address(rom_address[1]), .rom_req(rom_req[1]),
    .rom_data(rom_data[1]), .redirect(redirect), .redirect_target(redirect_target),
    .stall_d(stall_d), .instr_d(instr_d[1]), .pc_d(pc_d[1]), .pc_plus4_d(pc_plus4_d[1]),
    .valid_d(valid_d[1]), .queue_count(queue_count[1]));

  fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .ROM_LATENCY(1), .RESET_PC(RPC_C), .NOP_INSTR(NOP)) dut_c (
    .clock(clock), .reset(reset), .rom_address(rom_address[2]), .rom_req(rom_req[2]),
    .rom_data(rom_data[2]), .redirect(redirect), .redirect_target(redirect_target),
    .stall_d(stall_d), .instr_d(instr_d[2]), .pc_d(pc_d[2]), .pc_plus4_d(pc_plus4_d[2]),
    .valid_d(valid_d[2]), .queue_count(queue_count[2]));

  // ROM contents: word at address A is A>>2.
  always @(posedge clock) begin
    rom_q0 <= rom_address[0] >> 2;
    rom_q2 <= rom_address[2] >> 2;
  end
  assign rom_data[0] = rom_q0;
  assign rom_data[1] = rom_address[1] >> 2;
  assign rom_data[2] = rom_q2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic logic [31:0] rpc_of(input int d);
    return (d == 2) ? RPC_C : 32'h0;
  endfunction

  function automatic vec_t mk(input logic rst, input logic st, input logic v,
                              input logic [31:0] pc, input logic [31:0] addr,
                              input logic req, input logic [2:0] qc);
    vec_t r;
    r.rst = rst; r.stall = st; r.v = v; r.pc = pc; r.addr = addr; r.req = req; r.qc = qc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      mp[d].delete();
      mf[d] = rpc_of(d);
    end
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  task automatic step_models();
    if (reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic deq;
        logic iss;
        if (redirect) begin
          mq[d].delete();
          mp[d].delete();
          mf[d] = redirect_target;
        end else begin
          deq = (mq[d].size() != 0) && !stall_d;
          iss = (mq[d].size() + mp[d].size()) < NQ;
          if (deq) void'(mq[d].pop_front());
          if (mp[d].size() != 0) mq[d].push_back(mp[d].pop_front());
          if (iss) begin
            if (lat_of(d) == 0) mq[d].push_back(mf[d]);
            else                mp[d].push_back(mf[d]);
            mf[d] = mf[d] + 32'd4;
          end
        end
      end
    end
  endtask

  task automatic check_models();
    for (int d = 0; d < 3; d++) begin
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        rq;
      int          occ;
      occ = mq[d].size() + mp[d].size();
      v   = (mq[d].size() != 0);
      pc  = v ? mq[d][0] : 32'h0;
      ins = v ? (pc >> 2) : NOP;
      rq  = !reset && !redirect && (occ < NQ);
      chk($sformatf("dut%0d valid_d", d),     32'(valid_d[d]),     32'(v));
      chk($sformatf("dut%0d pc_d", d),        pc_d[d],             pc);
      chk($sformatf("dut%0d instr_d", d),     instr_d[d],          ins);
      chk($sformatf("dut%0d pc_plus4_d", d),  pc_plus4_d[d],       pc + 32'd4);
      chk($sformatf("dut%0d rom_address", d), rom_address[d],      mf[d]);
      chk($sformatf("dut%0d rom_req", d),     32'(rom_req[d]),     32'(rq));
      chk($sformatf("dut%0d queue_count", d), 32'(queue_count[d]), 32'(occ));
    end
  endtask

  task automatic drive_and_sample(input logic st, input logic rd, input logic [31:0] tgt);
    stall_d = st;
    redirect = rd;
    redirect_target = tgt;
    @(negedge clock);
    check_models();
  endtask

  task automatic advance();
    @(posedge clock);
    step_models();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    stall_d = 1'b0;
    redirect = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    stall_d = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Startup with no stall, then a 10-cycle stall that fills the queue.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  32'h00, 1'b1, 3'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 3'd1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 32'h0,  32'h08, 1'b1, 3'd2);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 32'h4,  32'h0C, 1'b1, 3'd2);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'h8,  32'h10, 1'b1, 3'd2);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,  32'h00, 1'b1, 3'd0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  32'h04, 1'b1, 3'd1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 32'h0,  32'h08, 1'b1, 3'd2);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 32'h0,  32'h0C, 1'b1, 3'd3);
    for (int i = 9; i < 15; i++) tbl[i] = mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 1'b0, 3'd4);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 32'h0,  32'h10, 1'b0, 3'd4);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 32'h4,  32'h10, 1'b1, 3'd3);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 32'h8,  32'h14, 1'b1, 3'd3);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 32'hC,  32'h18, 1'b1, 3'd3);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 32'h10, 32'h1C, 1'b1, 3'd3);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) apply_reset();
      drive_and_sample(tbl[i].stall, 1'b0, 32'h0);
      chk($sformatf("tbl%0d valid_d", i),     32'(valid_d[0]),     32'(tbl[i].v));
      chk($sformatf("tbl%0d pc_d", i),        pc_d[0],             tbl[i].pc);
      chk($sformatf("tbl%0d instr_d", i),     instr_d[0],          tbl[i].v ? (tbl[i].pc >> 2) : NOP);
      chk($sformatf("tbl%0d pc_plus4_d", i),  pc_plus4_d[0],       tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d rom_address", i), rom_address[0],      tbl[i].addr);
      chk($sformatf("tbl%0d rom_req", i),     32'(rom_req[0]),     32'(tbl[i].req));
      chk($sformatf("tbl%0d queue_count", i), 32'(queue_count[0]), 32'(tbl[i].qc));
      advance();
    end

    // Redirect together with stall while the latency-1 queue holds 3 + 1 pending.
    apply_reset();
    repeat (4) begin
      drive_and_sample(1'b1, 1'b0, 32'h0);
      advance();
    end
    drive_and_sample(1'b1, 1'b1, 32'h100);
    chk("redir a queue_count before", 32'(queue_count[0]), 32'd4);
    chk("redir a rom_req in redirect", 32'(rom_req[0]), 32'd0);
    advance();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("redir a queue_count after", 32'(queue_count[0]), 32'd0);
    chk("redir a valid_d after", 32'(valid_d[0]), 32'd0);
    chk("redir a rom_address after", rom_address[0], 32'h100);
    chk("redir b rom_address after", rom_address[1], 32'h100);
    advance();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("redir b valid_d +2", 32'(valid_d[1]), 32'd1);
    chk("redir b pc_d +2", pc_d[1], 32'h100);
    chk("redir a valid_d +2", 32'(valid_d[0]), 32'd0);
    advance();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("redir a valid_d +3", 32'(valid_d[0]), 32'd1);
    chk("redir a pc_d +3", pc_d[0], 32'h100);
    chk("redir a instr_d +3", instr_d[0], 32'h40);
    advance();

    // Address wrap on the instance that starts near the top of memory.
    apply_reset();
    repeat (2) begin
      drive_and_sample(1'b0, 1'b0, 32'h0);
      advance();
    end
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("wrap pc_d first", pc_d[2], 32'hFFFF_FFF8);
    advance();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("wrap pc_d second", pc_d[2], 32'hFFFF_FFFC);
    chk("wrap pc_plus4_d second", pc_plus4_d[2], 32'h0);
    advance();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    chk("wrap pc_d third", pc_d[2], 32'h0);
    advance();

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      int          r;
      st = ($urandom_range(0, 9) < 4);
      rd = ($urandom_range(0, 15) == 0);
      r  = $urandom_range(0, 7);
      tgt = (r == 0) ? 32'($urandom) : (r == 1) ? 32'hFFFF_FFF0 : (32'($urandom) & 32'h0000_0FFC);
      drive_and_sample(st, rd, tgt);
      advance();
    end

    // Asynchronous reset landing between clock edges.
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async dut%0d valid_d", d),     32'(valid_d[d]),     32'd0);
      chk($sformatf("async dut%0d instr_d", d),     instr_d[d],          NOP);
      chk($sformatf("async dut%0d pc_d", d),        pc_d[d],             32'h0);
      chk($sformatf("async dut%0d pc_plus4_d", d),  pc_plus4_d[d],       32'h4);
      chk($sformatf("async dut%0d rom_req", d),     32'(rom_req[d]),     32'd0);
      chk($sformatf("async dut%0d queue_count", d), 32'(queue_count[d]), 32'd0);
      chk($sformatf("async dut%0d rom_address", d), rom_address[d],      rpc_of(d));
    end
    model_reset();
    drive_and_sample(1'b0, 1'b0, 32'h0);
    advance();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      drive_and_sample($urandom_range(0, 3) == 0, 1'b0, 32'h0);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
